// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
// Multiply/divide unit for the E stage of a five-stage MIPS pipeline. Holds the
// architectural HI/LO registers, computes mult/div results when an op is
// accepted and commits them after a fixed multi-cycle latency, during which
// busy is high.
//
// Ports:
//   clk      in   1   pipeline clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   E-stage instruction is an MDU op
//   op       in   4   operation code (1 MULT .. 8 MTLO, others NONE)
//   rs_val   in  32   forwarded rs operand
//   rt_val   in  32   forwarded rt operand
//   req      in   1   exception/interrupt taken; cancels the E-stage op
//   busy     out  1   multi-cycle operation in flight (registered)
//   rd_data  out 32   HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo   out 32   architectural HI/LO
// -----------------------------------------------------------------------------
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // State and datapath registers
    state_t              r_state;
    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_pend_hi;
    logic [DATA_W-1:0]   r_pend_lo;
    logic                r_pend_vld;

    // Next-state values
    state_t              w_state_nxt;
    logic                w_busy_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_hi_nxt;
    logic [DATA_W-1:0]   w_lo_nxt;
    logic [DATA_W-1:0]   w_pend_hi_nxt;
    logic [DATA_W-1:0]   w_pend_lo_nxt;
    logic                w_pend_vld_nxt;

    logic                w_accept;

    // Multiply: the low 64 bits of a 64x64 product of sign-extended operands
    // equal the signed 32x32 product, so no signed arithmetic types are needed.
    logic [63:0]         w_prod_s;
    logic [63:0]         w_prod_u;

    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Divide: signed path works on magnitudes, then restores signs so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // A zero divisor is replaced by 1 only to keep the divider well defined;
    // that result is never committed. 0x80000000 / -1 falls out naturally:
    // magnitude 0x80000000 negated wraps back to 0x80000000.
    logic                w_div_zero;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W-1:0]   w_dvsr_s;
    logic [DATA_W-1:0]   w_dvsr_u;
    logic [DATA_W-1:0]   w_q_mag;
    logic [DATA_W-1:0]   w_r_mag;
    logic [DATA_W-1:0]   w_q_s;
    logic [DATA_W-1:0]   w_r_s;
    logic [DATA_W-1:0]   w_q_u;
    logic [DATA_W-1:0]   w_r_u;

    assign w_div_zero = (rt_val == '0);
    assign w_abs_a    = rs_val[31] ? (-rs_val) : rs_val;
    assign w_abs_b    = rt_val[31] ? (-rt_val) : rt_val;
    assign w_dvsr_s   = w_div_zero ? DATA_W'(1) : w_abs_b;
    assign w_dvsr_u   = w_div_zero ? DATA_W'(1) : rt_val;
    assign w_q_mag    = w_abs_a / w_dvsr_s;
    assign w_r_mag    = w_abs_a % w_dvsr_s;
    assign w_q_s      = (rs_val[31] ^ rt_val[31]) ? (-w_q_mag) : w_q_mag;
    assign w_r_s      = rs_val[31] ? (-w_r_mag) : w_r_mag;
    assign w_q_u      = rs_val / w_dvsr_u;
    assign w_r_u      = rs_val % w_dvsr_u;

    // An op only takes effect when idle and not cancelled by an exception
    assign w_accept = start && !req && !r_busy;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_pend_hi  <= '0;
            r_pend_lo  <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_pend_hi  <= w_pend_hi_nxt;
            r_pend_lo  <= w_pend_lo_nxt;
            r_pend_vld <= w_pend_vld_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in RUN, commit on the last cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_pend_hi_nxt  = r_pend_hi;
        w_pend_lo_nxt  = r_pend_lo;
        w_pend_vld_nxt = r_pend_vld;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_MULT: begin
                            w_pend_hi_nxt  = w_prod_s[63:32];
                            w_pend_lo_nxt  = w_prod_s[31:0];
                            w_pend_vld_nxt = 1'b1;
                            w_cnt_nxt      = CNT_W'(MULT_CYCLES);
                            w_state_nxt    = S_RUN;
                        end
                        OP_MULTU: begin
                            w_pend_hi_nxt  = w_prod_u[63:32];
                            w_pend_lo_nxt  = w_prod_u[31:0];
                            w_pend_vld_nxt = 1'b1;
                            w_cnt_nxt      = CNT_W'(MULT_CYCLES);
                            w_state_nxt    = S_RUN;
                        end
                        OP_DIV: begin
                            w_pend_hi_nxt  = w_div_zero ? '0 : w_r_s;
                            w_pend_lo_nxt  = w_div_zero ? '0 : w_q_s;
                            w_pend_vld_nxt = !w_div_zero;
                            w_cnt_nxt      = CNT_W'(DIV_CYCLES);
                            w_state_nxt    = S_RUN;
                        end
                        OP_DIVU: begin
                            w_pend_hi_nxt  = w_div_zero ? '0 : w_r_u;
                            w_pend_lo_nxt  = w_div_zero ? '0 : w_q_u;
                            w_pend_vld_nxt = !w_div_zero;
                            w_cnt_nxt      = CNT_W'(DIV_CYCLES);
                            w_state_nxt    = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = rs_val;
                        OP_MTLO: w_lo_nxt = rs_val;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // req is ignored here: the in-flight op belongs to an older instruction
                if (r_cnt == CNT_W'(1)) begin
                    if (r_pend_vld) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                    w_pend_vld_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == S_RUN);
    end

    // Read port for MFHI/MFLO
    always_comb begin
        rd_data = '0;
        if (op == OP_MFHI) begin
            rd_data = r_hi;
        end else if (op == OP_MFLO) begin
            rd_data = r_lo;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit
// Directed bench for mdu_unit: drives ops one after another from a single
// initial block and checks busy duration and HI/LO/rd_data against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        req;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int n_busy;

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .req    (req),
        .busy   (busy),
        .rd_data(rd_data),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for exactly one edge
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        step();
        start  = 1'b0;
        op     = 4'd0;
        rs_val = '0;
        rt_val = '0;
    endtask

    // Count sampled cycles with busy high, bounded so a stuck busy cannot hang the run
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 4'd0;
        rs_val = '0;
        rt_val = '0;
        req    = 1'b0;
        step();
        step();

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        step();

        // MULT -3 * 7 = -21
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        wait_idle(n_busy);
        check("mult_busy_cycles", 32'(n_busy), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        // MULTU 0xFFFFFFFF * 2
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n_busy);
        check("multu_busy_cycles", 32'(n_busy), 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // MFHI / MFLO read ports
        start = 1'b1;
        op    = 4'd5;
        #1;
        check("mfhi_rd_data", rd_data, 32'h0000_0001);
        op = 4'd6;
        #1;
        check("mflo_rd_data", rd_data, 32'hFFFF_FFFE);
        op = 4'd7;
        #1;
        check("mthi_rd_data_zero", rd_data, 32'h0);
        start = 1'b0;
        op    = 4'd0;
        step();

        // DIV -7 / 2 = -3 rem -1
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_busy_after_accept", {31'd0, busy}, 32'd1);
        wait_idle(n_busy);
        check("div_busy_cycles", 32'(n_busy), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV overflow case 0x80000000 / -1
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n_busy);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        // DIV 7 / -2 = -3 rem 1 (remainder follows dividend)
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n_busy);
        check("div_negdvsr_lo", lo, 32'hFFFF_FFFD);
        check("div_negdvsr_hi", hi, 32'h0000_0001);

        // MTHI / MTLO take effect at the accept edge with no busy
        issue(4'd7, 32'h0000_1234, 32'h0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h0000_1234);
        issue(4'd8, 32'h0000_5678, 32'h0);
        check("mtlo_lo", lo, 32'h0000_5678);

        // DIVU by zero: busy full duration, HI/LO untouched
        issue(4'd4, 32'd9, 32'd0);
        wait_idle(n_busy);
        check("divu0_busy_cycles", 32'(n_busy), 32'd10);
        check("divu0_hi", hi, 32'h0000_1234);
        check("divu0_lo", lo, 32'h0000_5678);

        // MULT cancelled by req at the same edge
        req = 1'b1;
        issue(4'd1, 32'd3, 32'd3);
        req = 1'b0;
        check("req_cancel_busy", {31'd0, busy}, 32'd0);
        check("req_cancel_hi", hi, 32'h0000_1234);
        check("req_cancel_lo", lo, 32'h0000_5678);

        // DIVU 100 / 7 = 14 rem 2 with a req pulse mid-flight
        issue(4'd4, 32'd100, 32'd7);
        step();
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        wait_idle(n_busy);
        check("req_inflight_busy_cycles", 32'(n_busy + 3), 32'd10);
        check("req_inflight_lo", lo, 32'd14);
        check("req_inflight_hi", hi, 32'd2);

        // Back-to-back: MTHI presented at the edge where busy falls is ignored
        issue(4'd2, 32'd3, 32'd4);
        step();
        step();
        step();
        step();
        check("b2b_busy_before_fall", {31'd0, busy}, 32'd1);
        start  = 1'b1;
        op     = 4'd7;
        rs_val = 32'h0000_DEAD;
        step();
        start  = 1'b0;
        op     = 4'd0;
        rs_val = '0;
        check("b2b_busy_fell", {31'd0, busy}, 32'd0);
        check("b2b_hi", hi, 32'h0);
        check("b2b_lo", lo, 32'd12);

        // Reset mid-DIV: immediate clear, no later commit
        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("rst_mid_busy_after", {31'd0, busy}, 32'd0);
        check("rst_mid_hi_after", hi, 32'h0);
        check("rst_mid_lo_after", lo, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
